pipeline_memory_stage_hs: RTL and testbench

- Parametrised successor of the MEM pipeline stage. Sits between EXECUTE and WRITEBACK.
- Replaces the fixed single-cycle RAM access with a req/ready/rvalid handshake to a variable-latency memory.
- Adds upstream stall, downstream backpressure and a wait-timeout fault.
- Non-memory instructions still pass through in one cycle.

---
 rtl/pipeline_memory_stage_hs.sv | 247 ++++++++++++++++++++++++
 tb/tb_pipeline_memory_stage_hs.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_memory_stage_hs.sv
// -----------------------------------------------------------------------------
// pipeline_memory_stage_hs
//
// MEM pipeline stage between EXECUTE and WRITEBACK. Non-memory instructions
// pass through with one cycle of latency. LDR/STR are issued to a
// variable-latency memory over a req/ready/rvalid handshake. A per-access
// wait counter raises a sticky fault and retires the instruction if the
// memory does not respond in time.
//
// Ports
//   clk, reset             rising-edge clock, asynchronous active-low reset
//   execute_*              instruction offered by EXECUTE (held while stalled)
//   writeback_stall        downstream cannot accept; stage outputs hold
//   memory_stall           upstream must hold execute_* this cycle
//   memory_rn_num/rt_num   register-file read indices from execute_instr
//   memory_rn, memory_rt   register values (base address, store data)
//   mem_req/we/addr/wdata  request channel to memory
//   mem_ready              memory accepts the request this cycle
//   mem_rvalid/rdata       read response channel
//   memory_done/...        registered stage outputs towards WRITEBACK
//   memory_fault           sticky wait-timeout flag
// -----------------------------------------------------------------------------
module pipeline_memory_stage_hs #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               execute_done,
  input  logic               execute_is_dependent,
  input  logic [DATA_W-1:0]  execute_result,
  input  logic [INSTR_W-1:0] execute_instr,
  input  logic               writeback_stall,
  output logic               memory_stall,
  output logic [2:0]         memory_rn_num,
  output logic [2:0]         memory_rt_num,
  input  logic [DATA_W-1:0]  memory_rn,
  input  logic [DATA_W-1:0]  memory_rt,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_ready,
  input  logic               mem_rvalid,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               memory_done,
  output logic               memory_is_dependent,
  output logic [DATA_W-1:0]  memory_result,
  output logic [INSTR_W-1:0] memory_instr,
  output logic               memory_fault
);

  localparam int unsigned CNT_W  = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [3:0]  OP_LDR = 4'b0100;
  localparam logic [3:0]  OP_STR = 4'b0101;

  // S_HOLD: the memory access has finished but WRITEBACK is stalled; the
  // result waits in hold_q so the request can be dropped without data loss.
  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [INSTR_W-1:0]  linstr_q, linstr_d;
  logic [DATA_W-1:0]   lres_q, lres_d;
  logic                ldep_q, ldep_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                done_q, done_d;
  logic                dep_q, dep_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                fault_q, fault_d;

  logic [3:0]          opcode;
  logic                is_mem;
  logic                is_str;
  logic                timeout;
  logic                cmpl;
  logic [DATA_W-1:0]   cmpl_data;

  assign opcode  = execute_instr[INSTR_W-1 -: 4];
  assign is_str  = (opcode == OP_STR);
  assign is_mem  = (opcode == OP_LDR) || is_str;
  assign timeout = (cnt_q == CNT_W'(MAX_WAIT));

  assign memory_rn_num       = execute_instr[5:3];
  assign memory_rt_num       = execute_instr[2:0];
  assign memory_stall        = (state_q != S_IDLE) || writeback_stall;
  assign mem_req             = (state_q == S_REQ);
  assign mem_we              = we_q;
  assign mem_addr            = addr_q;
  assign mem_wdata           = wdata_q;
  assign memory_done         = done_q;
  assign memory_is_dependent = dep_q;
  assign memory_result       = result_q;
  assign memory_instr        = instr_q;
  assign memory_fault        = fault_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    linstr_d  = linstr_q;
    lres_d    = lres_q;
    ldep_d    = ldep_q;
    hold_d    = hold_q;
    done_d    = done_q;
    dep_d     = dep_q;
    result_d  = result_q;
    instr_d   = instr_q;
    fault_d   = fault_q;
    cmpl      = 1'b0;
    cmpl_data = lres_q;

    unique case (state_q)
      S_IDLE: begin
        if (!writeback_stall) begin
          if (execute_done) begin
            if (is_mem) begin
              linstr_d = execute_instr;
              lres_d   = execute_result;
              ldep_d   = execute_is_dependent;
              addr_d   = ADDR_W'(memory_rn);
              wdata_d  = memory_rt;
              we_d     = is_str;
              cnt_d    = '0;
              done_d   = 1'b0;
              state_d  = S_REQ;
            end else begin
              done_d   = 1'b1;
              result_d = execute_result;
              instr_d  = execute_instr;
              dep_d    = execute_is_dependent;
            end
          end else begin
            done_d = 1'b0;
          end
        end
      end

      S_REQ: begin
        // A real handshake in the last allowed cycle wins over the timeout.
        if (mem_ready && we_q) begin
          cmpl      = 1'b1;
          cmpl_data = lres_q;
        end else if (mem_ready && mem_rvalid) begin
          cmpl      = 1'b1;
          cmpl_data = mem_rdata;
        end else if (timeout) begin
          fault_d   = 1'b1;
          cmpl      = 1'b1;
          cmpl_data = we_q ? lres_q : '0;
        end else if (mem_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        if (mem_rvalid) begin
          cmpl      = 1'b1;
          cmpl_data = mem_rdata;
        end else if (timeout) begin
          fault_d   = 1'b1;
          cmpl      = 1'b1;
          cmpl_data = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (!writeback_stall) begin
          done_d   = 1'b1;
          result_d = hold_q;
          instr_d  = linstr_q;
          dep_d    = ldep_q;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (cmpl) begin
      cnt_d = '0;
      if (writeback_stall) begin
        hold_d  = cmpl_data;
        state_d = S_HOLD;
      end else begin
        done_d   = 1'b1;
        result_d = cmpl_data;
        instr_d  = linstr_q;
        dep_d    = ldep_q;
        state_d  = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      linstr_q <= '0;
      lres_q   <= '0;
      ldep_q   <= 1'b0;
      hold_q   <= '0;
      done_q   <= 1'b0;
      dep_q    <= 1'b0;
      result_q <= '0;
      instr_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      linstr_q <= linstr_d;
      lres_q   <= lres_d;
      ldep_q   <= ldep_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      dep_q    <= dep_d;
      result_q <= result_d;
      instr_q  <= instr_d;
      fault_q  <= fault_d;
    end
  end

endmodule

// File: tb/tb_pipeline_memory_stage_hs.sv
// -----------------------------------------------------------------------------
// tb_pipeline_memory_stage_hs
//
// Directed scenarios (reset, pass-through, store with wait states, zero-wait
// load, load completing under downstream stall, timeout) followed by a
// randomized phase. In the randomized phase a behavioural memory answers
// requests with random wait states, and an in-order scoreboard of expected
// retirements (computed at issue time from an array model of memory) is
// compared with every output WRITEBACK consumes.
// -----------------------------------------------------------------------------
module tb_pipeline_memory_stage_hs;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned MAX_WAIT = 15;

  logic               clk;
  logic               reset;
  logic               execute_done;
  logic               execute_is_dependent;
  logic [DATA_W-1:0]  execute_result;
  logic [INSTR_W-1:0] execute_instr;
  logic               writeback_stall;
  logic               memory_stall;
  logic [2:0]         memory_rn_num;
  logic [2:0]         memory_rt_num;
  logic [DATA_W-1:0]  memory_rn;
  logic [DATA_W-1:0]  memory_rt;
  logic               mem_req;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic               mem_ready;
  logic               mem_rvalid;
  logic [DATA_W-1:0]  mem_rdata;
  logic               memory_done;
  logic               memory_is_dependent;
  logic [DATA_W-1:0]  memory_result;
  logic [INSTR_W-1:0] memory_instr;
  logic               memory_fault;

  pipeline_memory_stage_hs #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .execute_done        (execute_done),
    .execute_is_dependent(execute_is_dependent),
    .execute_result      (execute_result),
    .execute_instr       (execute_instr),
    .writeback_stall     (writeback_stall),
    .memory_stall        (memory_stall),
    .memory_rn_num       (memory_rn_num),
    .memory_rt_num       (memory_rt_num),
    .memory_rn           (memory_rn),
    .memory_rt           (memory_rt),
    .mem_req             (mem_req),
    .mem_we              (mem_we),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_ready           (mem_ready),
    .mem_rvalid          (mem_rvalid),
    .mem_rdata           (mem_rdata),
    .memory_done         (memory_done),
    .memory_is_dependent (memory_is_dependent),
    .memory_result       (memory_result),
    .memory_instr        (memory_instr),
    .memory_fault        (memory_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model state for the randomized phase ----------
  typedef struct {
    logic [15:0] instr;
    logic [15:0] result;
    logic        dep;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ref_mem  [16];
  logic [15:0] phys_mem [16];

  bit          off_act;
  logic [15:0] off_instr, off_res, off_rn, off_rt;
  logic        off_dep;

  logic [15:0] cur_addr, cur_wdata;
  logic        cur_we;

  bit          in_req, rd_pend;
  int unsigned req_wait, rd_cnt;
  logic [3:0]  rd_idx;

  task automatic rnd_cycle(input bit allow_new);
    int unsigned d;
    logic [3:0]  op;
    exp_t        e;

    // Behavioural memory: random wait before ready, random read latency.
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 16'($urandom);
    if (rd_pend) begin
      if (rd_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = phys_mem[rd_idx];
        rd_pend    = 1'b0;
      end else begin
        rd_cnt--;
      end
    end else if (mem_req) begin
      if (!in_req) begin
        in_req   = 1'b1;
        req_wait = $urandom % 4;
      end
      if (req_wait == 0) begin
        mem_ready = 1'b1;
        in_req    = 1'b0;
        if (mem_we) begin
          phys_mem[mem_addr[3:0]] = mem_wdata;
        end else begin
          d = $urandom % 4;
          if (d == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = phys_mem[mem_addr[3:0]];
          end else begin
            rd_pend = 1'b1;
            rd_cnt  = d - 1;
            rd_idx  = mem_addr[3:0];
          end
        end
      end else begin
        req_wait--;
      end
    end else if ($urandom % 8 == 0) begin
      mem_rvalid = 1'b1;  // stray response, must be ignored
    end

    // Upstream: new instruction offered and held until accepted.
    if (!off_act && allow_new && ($urandom % 10 < 7)) begin
      case ($urandom % 4)
        0:       op = 4'b0100;
        1:       op = 4'b0101;
        default: begin
          op = 4'($urandom);
          if (op == 4'b0100 || op == 4'b0101) op = 4'b0000;
        end
      endcase
      off_instr = {op, 12'($urandom)};
      off_res   = 16'($urandom);
      off_dep   = 1'($urandom);
      off_rn    = 16'($urandom);
      off_rt    = 16'($urandom);
      off_act   = 1'b1;
    end
    execute_done         = off_act;
    execute_instr        = off_act ? off_instr : 16'($urandom);
    execute_result       = off_res;
    execute_is_dependent = off_dep;
    memory_rn            = off_rn;
    memory_rt            = off_rt;
    writeback_stall      = ($urandom % 4 == 0);
    #1;

    if (mem_req && mem_ready) begin
      chk16("hs_addr", mem_addr, cur_addr);
      chk1("hs_we", mem_we, cur_we);
      if (cur_we) chk16("hs_wdata", mem_wdata, cur_wdata);
    end

    if (memory_done && !writeback_stall) begin
      if (sb.size() == 0) begin
        chk1("sb_spurious_done", memory_done, 1'b0);
      end else begin
        e = sb.pop_front();
        chk16("sb_instr", memory_instr, e.instr);
        chk16("sb_result", memory_result, e.result);
        chk1("sb_dep", memory_is_dependent, e.dep);
      end
    end

    if (execute_done && !memory_stall) begin
      chk16("rn_num", 16'(memory_rn_num), 16'(off_instr[5:3]));
      chk16("rt_num", 16'(memory_rt_num), 16'(off_instr[2:0]));
      e.instr = off_instr;
      e.dep   = off_dep;
      op      = off_instr[15:12];
      if (op == 4'b0100) begin
        e.result = ref_mem[off_rn[3:0]];
      end else begin
        e.result = off_res;
        if (op == 4'b0101) ref_mem[off_rn[3:0]] = off_rt;
      end
      if (op == 4'b0100 || op == 4'b0101) begin
        cur_addr  = off_rn;
        cur_wdata = off_rt;
        cur_we    = (op == 4'b0101);
      end
      sb.push_back(e);
      off_act = 1'b0;
    end

    @(posedge clk);
    #1;
  endtask

  initial begin
    int stall_cnt;
    int edges;
    int guard;

    reset = 1'b0;
    execute_done = 1'b0; execute_is_dependent = 1'b0;
    execute_result = '0; execute_instr = '0;
    writeback_stall = 1'b0; memory_rn = '0; memory_rt = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset values
    #2;
    chk1("rst_done", memory_done, 1'b0);
    chk16("rst_result", memory_result, 16'h0000);
    chk16("rst_instr", memory_instr, 16'h0000);
    chk1("rst_dep", memory_is_dependent, 1'b0);
    chk1("rst_req", mem_req, 1'b0);
    chk1("rst_fault", memory_fault, 1'b0);
    chk1("rst_stall", memory_stall, 1'b0);
    #6;
    reset = 1'b1;
    tick();

    // Non-memory pass-through, one cycle latency
    execute_done = 1'b1; execute_instr = 16'h1234;
    execute_result = 16'h00FF; execute_is_dependent = 1'b1;
    #1;
    chk1("add_stall_pre", memory_stall, 1'b0);
    tick();
    execute_done = 1'b0; execute_is_dependent = 1'b0;
    chk1("add_done", memory_done, 1'b1);
    chk16("add_result", memory_result, 16'h00FF);
    chk16("add_instr", memory_instr, 16'h1234);
    chk1("add_dep", memory_is_dependent, 1'b1);
    chk1("add_stall", memory_stall, 1'b0);
    tick();
    chk1("bubble_done", memory_done, 1'b0);

    // Store with three wait states
    execute_done = 1'b1; execute_instr = 16'h5008; execute_result = 16'h5555;
    memory_rn = 16'h0040; memory_rt = 16'hBEEF; mem_ready = 1'b0;
    tick();
    execute_done = 1'b0; memory_rn = '0; memory_rt = '0;
    chk1("str_done_low", memory_done, 1'b0);
    stall_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      mem_ready = (c == 3);
      #1;
      chk1("str_req", mem_req, 1'b1);
      chk16("str_addr", mem_addr, 16'h0040);
      chk1("str_we", mem_we, 1'b1);
      chk16("str_wdata", mem_wdata, 16'hBEEF);
      if (memory_stall) stall_cnt++;
      tick();
    end
    mem_ready = 1'b0;
    chk16("str_stall_cycles", 16'(stall_cnt), 16'd4);
    chk1("str_done", memory_done, 1'b1);
    chk16("str_result", memory_result, 16'h5555);
    chk16("str_instr", memory_instr, 16'h5008);
    chk1("str_req_after", mem_req, 1'b0);
    chk1("str_stall_after", memory_stall, 1'b0);

    // Zero-wait load: result two edges after accept
    execute_done = 1'b1; execute_instr = 16'h4010; execute_result = 16'h0BAD;
    memory_rn = 16'h0010;
    tick();
    execute_done = 1'b0;
    chk1("ldr_done_low", memory_done, 1'b0);
    chk1("ldr_req", mem_req, 1'b1);
    chk16("ldr_addr", mem_addr, 16'h0010);
    chk1("ldr_we", mem_we, 1'b0);
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'hCAFE;
    tick();
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    chk1("ldr_done", memory_done, 1'b1);
    chk16("ldr_result", memory_result, 16'hCAFE);
    chk16("ldr_instr", memory_instr, 16'h4010);

    // Load completing while WRITEBACK stalls for two cycles
    execute_done = 1'b1; execute_instr = 16'h2000; execute_result = 16'h2222;
    tick();
    chk16("add2_result", memory_result, 16'h2222);
    execute_instr = 16'h4018; memory_rn = 16'h0020;
    tick();
    execute_done = 1'b0;
    writeback_stall = 1'b1; mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'hCAFE;
    tick();
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'hDEAD;
    chk16("wbs_hold_result1", memory_result, 16'h2222);
    chk1("wbs_hold_done1", memory_done, 1'b0);
    chk1("wbs_req_low", mem_req, 1'b0);
    chk1("wbs_stall", memory_stall, 1'b1);
    tick();
    chk16("wbs_hold_result2", memory_result, 16'h2222);
    chk1("wbs_hold_done2", memory_done, 1'b0);
    writeback_stall = 1'b0;
    tick();
    chk1("wbs_done", memory_done, 1'b1);
    chk16("wbs_result", memory_result, 16'hCAFE);
    chk16("wbs_instr", memory_instr, 16'h4018);

    // Timeout: accepted request, read data never returned
    execute_done = 1'b1; execute_instr = 16'h4020; execute_result = 16'h3333;
    memory_rn = 16'h0030;
    tick();
    execute_done = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    edges = 1;
    while (!memory_done && edges < 40) begin
      tick();
      edges++;
    end
    chk16("to_latency", 16'(edges), 16'(MAX_WAIT + 1));
    chk1("to_fault", memory_fault, 1'b1);
    chk1("to_done", memory_done, 1'b1);
    chk16("to_result", memory_result, 16'h0000);
    mem_rvalid = 1'b1; mem_rdata = 16'hBAD1;
    tick();
    mem_rvalid = 1'b0;
    chk1("stray_done", memory_done, 1'b0);
    chk16("stray_result", memory_result, 16'h0000);
    chk1("fault_sticky", memory_fault, 1'b1);
    chk1("stray_stall", memory_stall, 1'b0);

    // Asynchronous reset in the middle of a request
    execute_done = 1'b1; execute_instr = 16'h1000; execute_result = 16'h7777;
    tick();
    execute_instr = 16'h5000; memory_rn = 16'h0050;
    tick();
    execute_done = 1'b0;
    #1;
    chk1("mid_req", mem_req, 1'b1);
    chk16("mid_result", memory_result, 16'h7777);
    #2;
    reset = 1'b0;
    #1;
    chk1("arst_req", mem_req, 1'b0);
    chk1("arst_done", memory_done, 1'b0);
    chk16("arst_result", memory_result, 16'h0000);
    chk16("arst_instr", memory_instr, 16'h0000);
    chk1("arst_fault", memory_fault, 1'b0);
    chk1("arst_stall", memory_stall, 1'b0);
    chk16("arst_addr", mem_addr, 16'h0000);
    #1;
    reset = 1'b1;
    tick();
    chk1("post_rst_req", mem_req, 1'b0);
    chk1("post_rst_done", memory_done, 1'b0);

    // Randomized phase against the scoreboard
    for (int i = 0; i < 16; i++) begin
      ref_mem[i]  = 16'($urandom);
      phys_mem[i] = ref_mem[i];
    end
    off_act = 1'b0; in_req = 1'b0; rd_pend = 1'b0;
    req_wait = 0; rd_cnt = 0; rd_idx = '0;
    cur_addr = '0; cur_wdata = '0; cur_we = 1'b0;
    off_instr = '0; off_res = '0; off_rn = '0; off_rt = '0; off_dep = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) rnd_cycle(1'b1);
    guard = 0;
    while ((off_act || sb.size() != 0) && guard < 300) begin
      rnd_cycle(1'b0);
      guard++;
    end
    chk16("drain_left", 16'(sb.size()), 16'd0);
    chk1("rand_fault", memory_fault, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
